// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands under valid/ready and
// drives the ALU. Optional EX/MEM + MEM/WB forwarding via `ID_EX_FORWARD_EN.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [2:0]      in_sel,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic [4:0]      exm_rd,
  input  logic [4:0]      wb_rd,
  input  logic            exm_we,
  input  logic            wb_we,
  input  logic [XLEN-1:0] exm_data,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [2:0]      sel,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            illegal_op
);

  logic            valid_q;
  logic [4:0]      rs1_addr_q;
  logic [4:0]      rs2_addr_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic            use_imm_q;
  logic [2:0]      sel_q;
  logic            reg_write_q;
  logic            capture;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  assign in_ready = !valid_q || out_ready;
  // flush beats a simultaneous capture; upstream still sees the handshake
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      sel_q       <= '0;
      reg_write_q <= 1'b0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      rs1_addr_q  <= in_rs1_addr;
      rs2_addr_q  <= in_rs2_addr;
      rd_q        <= in_rd_addr;
      rs1_data_q  <= in_rs1_data;
      rs2_data_q  <= in_rs2_data;
      imm_q       <= in_imm;
      use_imm_q   <= in_use_imm;
      sel_q       <= in_sel;
      reg_write_q <= in_reg_write;
    end else if (flush || (valid_q && out_ready)) begin
      valid_q <= 1'b0;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is younger than MEM/WB, so it takes priority; x0 never forwards
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]      addr,
                                              input logic [XLEN-1:0] reg_data,
                                              input logic            e_we,
                                              input logic [4:0]      e_rd,
                                              input logic [XLEN-1:0] e_data,
                                              input logic            w_we,
                                              input logic [4:0]      w_rd,
                                              input logic [XLEN-1:0] w_data);
    logic [XLEN-1:0] r;
    r = reg_data;
    if (e_we && (e_rd != 5'd0) && (e_rd == addr))
      r = e_data;
    else if (w_we && (w_rd != 5'd0) && (w_rd == addr))
      r = w_data;
    return r;
  endfunction

  always_comb begin
    rs1_fwd = fwd_sel(rs1_addr_q, rs1_data_q, exm_we, exm_rd, exm_data, wb_we, wb_rd, wb_data);
    rs2_fwd = fwd_sel(rs2_addr_q, rs2_data_q, exm_we, exm_rd, exm_data, wb_we, wb_rd, wb_data);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exm_rd, wb_rd, exm_we, wb_we, exm_data, wb_data,
                        rs1_addr_q, rs2_addr_q};

  always_comb begin
    rs1_fwd = rs1_data_q;
    rs2_fwd = rs2_data_q;
  end
`endif

  always_comb begin
    op_a          = rs1_fwd;
    op_b          = use_imm_q ? imm_q : rs2_fwd;
    sel           = sel_q;
    out_valid     = valid_q;
    out_rd        = rd_q;
    out_reg_write = valid_q && reg_write_q;
    illegal_op    = 1'b0;
    case (sel_q)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: illegal_op = 1'b0;
      default:                                illegal_op = valid_q;
    endcase
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus stall/flush/reset sequences.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm, in_reg_write, flush;
  logic [2:0]  in_sel;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_we, wb_we;
  logic [31:0] exm_data, wb_data;
  logic        out_valid, out_ready;
  logic [31:0] op_a, op_b;
  logic [2:0]  sel;
  logic [4:0]  out_rd;
  logic        out_reg_write, illegal_op;

  int checks = 0;
  int failures = 0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_sel(in_sel), .in_reg_write(in_reg_write),
    .flush(flush), .exm_rd(exm_rd), .wb_rd(wb_rd), .exm_we(exm_we), .wb_we(wb_we),
    .exm_data(exm_data), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .op_a(op_a), .op_b(op_b), .sel(sel), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic [2:0]  sel;
    logic        rw;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        w_we;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic [31:0] exp_a, exp_b;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fwd_idle();
    exm_we = 0; exm_rd = 0; exm_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [2:0] s);
    in_valid = 1; in_rs1_addr = r1; in_rs2_addr = r2; in_rd_addr = 5'd1;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = 0; in_use_imm = 0;
    in_sel = s; in_reg_write = 1;
  endtask

  initial begin
    vecs[0] = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd0, 1'b0, 3'b001, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd3, 1'b0};
    vecs[1] = '{5'd1, 5'd2, 5'd4, 32'd9, 32'd7, 32'hFFFF_FFF0, 1'b1, 3'b000, 1'b1,
                1'b1, 5'd2, 32'h1234, 1'b0, 5'd0, 32'd0, 32'd9, 32'hFFFF_FFF0, 1'b0};
    vecs[2] = '{5'd4, 5'd5, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 3'b010, 1'b1,
                1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB,
                FWD ? 32'hAA : 32'h11, 32'h22, 1'b0};
    vecs[3] = '{5'd4, 5'd5, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 3'b011, 1'b0,
                1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB,
                FWD ? 32'hBB : 32'h11, 32'h22, 1'b0};
    vecs[4] = '{5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b1,
                1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 32'd0, 32'd0, 1'b0};
    vecs[5] = '{5'd3, 5'd6, 5'd8, 32'h40, 32'h50, 32'd0, 1'b0, 3'b110, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h40, 32'h50, 1'b1};
    vecs[6] = '{5'd3, 5'd7, 5'd9, 32'h41, 32'd1, 32'd0, 1'b0, 3'b101, 1'b1,
                1'b1, 5'd8, 32'hEE, 1'b1, 5'd7, 32'hCC,
                32'h41, FWD ? 32'hCC : 32'd1, 1'b0};
    vecs[7] = '{5'd9, 5'd9, 5'd10, 32'hD1, 32'hD2, 32'd0, 1'b0, 3'b111, 1'b0,
                1'b1, 5'd9, 32'hDD, 1'b0, 5'd0, 32'd0,
                FWD ? 32'hDD : 32'hD1, FWD ? 32'hDD : 32'hD2, 1'b1};
    vecs[8] = '{5'd10, 5'd11, 5'd31, 32'h77, 32'h88, 32'd0, 1'b0, 3'b100, 1'b1,
                1'b0, 5'd10, 32'h99, 1'b0, 5'd10, 32'h98, 32'h77, 32'h88, 1'b1};

    rst_n = 0; out_ready = 1; flush = 0;
    in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0;
    in_sel = 0; in_reg_write = 0;
    fwd_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_sel", {29'd0, sel}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_reg_write", {31'd0, out_reg_write}, 32'd0);
    check("rst_illegal", {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1; in_rs1_addr = vecs[i].rs1; in_rs2_addr = vecs[i].rs2;
      in_rd_addr = vecs[i].rd; in_rs1_data = vecs[i].d1; in_rs2_data = vecs[i].d2;
      in_imm = vecs[i].imm; in_use_imm = vecs[i].use_imm; in_sel = vecs[i].sel;
      in_reg_write = vecs[i].rw;
      @(posedge clk);
      #1;
      in_valid = 0;
      exm_we = vecs[i].e_we; exm_rd = vecs[i].e_rd; exm_data = vecs[i].e_data;
      wb_we = vecs[i].w_we; wb_rd = vecs[i].w_rd; wb_data = vecs[i].w_data;
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("v%0d_op_a", i), op_a, vecs[i].exp_a);
      check($sformatf("v%0d_op_b", i), op_b, vecs[i].exp_b);
      check($sformatf("v%0d_sel", i), {29'd0, sel}, {29'd0, vecs[i].sel});
      check($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
      check($sformatf("v%0d_reg_write", i), {31'd0, out_reg_write}, {31'd0, vecs[i].rw});
      check($sformatf("v%0d_illegal", i), {31'd0, illegal_op}, {31'd0, vecs[i].exp_ill});
      fwd_idle();
    end

    // drain with no new capture: valid drops, fields hold
    @(posedge clk);
    #1;
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_op_a", op_a, 32'h77);
    check("drain_reg_write", {31'd0, out_reg_write}, 32'd0);
    check("drain_illegal", {31'd0, illegal_op}, 32'd0);

    // stall for 3 cycles with a new instruction waiting
    @(negedge clk);
    drive(5'd1, 5'd2, 32'd5, 32'd3, 3'b001);
    @(posedge clk);
    #1;
    out_ready = 0;
    drive(5'd1, 5'd2, 32'h100, 32'h200, 3'b010);
    #1;
    check("stall_in_ready0", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall%0d_op_a", c), op_a, 32'd5);
      check($sformatf("stall%0d_op_b", c), op_b, 32'd3);
      check($sformatf("stall%0d_sel", c), {29'd0, sel}, 32'd1);
      check($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1;
    #1;
    check("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("unstall_valid", {31'd0, out_valid}, 32'd1);
    check("unstall_op_a", op_a, 32'h100);
    check("unstall_op_b", op_b, 32'h200);
    check("unstall_sel", {29'd0, sel}, 32'd2);

    // flush collides with a capture: incoming instruction discarded
    drive(5'd1, 5'd2, 32'h300, 32'h301, 3'b011);
    flush = 1;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_op_a_hold", op_a, 32'h100);
    flush = 0;
    @(posedge clk);
    #1;
    in_valid = 0;
    check("post_flush_valid", {31'd0, out_valid}, 32'd1);
    check("post_flush_op_a", op_a, 32'h300);

    // flush of a stalled instruction
    out_ready = 0;
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    check("flush_stall_valid", {31'd0, out_valid}, 32'd0);

    // reset asserted mid-cycle during a stall
    out_ready = 1;
    drive(5'd1, 5'd2, 32'h400, 32'h401, 3'b110);
    @(posedge clk);
    #1;
    in_valid = 0;
    out_ready = 0;
    @(posedge clk);
    #1;
    check("pre_rst_op_a", op_a, 32'h400);
    check("pre_rst_illegal", {31'd0, illegal_op}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_op_a", op_a, 32'd0);
    check("mid_rst_op_b", op_b, 32'd0);
    check("mid_rst_sel", {29'd0, sel}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_illegal", {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
